// File: rtl/jpeg_bit_packer.sv
// jpeg_bit_packer
//   Packs right-aligned variable-length entropy codes (Huffman code followed by
//   magnitude bits) into MSB-first 32-bit words for the PISO byte streamer.
//   The block never stalls and emits at most one word per cycle. An
//   end-of-scan flush pads the residual bits with 1s, which JPEG accepts as
//   fill bits ahead of the EOI marker.
//
// Parameters
//   CODE_W      max code length in bits (<= 31)
//   LEN_W       width of code_len (2**LEN_W > CODE_W)
//
// Ports
//   clk         clock
//   nrst        asynchronous active-low reset
//   code_in     code bits, right-aligned, sent MSB first; bits above code_len ignored
//   code_len    number of valid code bits, 0..CODE_W
//   code_valid  qualifier for code_in/code_len
//   flush       single-cycle request to pad and emit the residual bits
//   dout        packed word (streamer din); holds its value between strobes
//   dout_valid  one-cycle word strobe (streamer din_valid)
//   flush_done  one-cycle pulse when a flush completes
//   err         sticky error: over-length code, or code offered during a flush
//   word_cnt    words emitted in the current scan, present only when
//               JPEG_BIT_PACKER_WCNT_EN is defined
//
// Optional feature macro: JPEG_BIT_PACKER_WCNT_EN

module jpeg_bit_packer #(
  parameter int unsigned CODE_W = 27,
  parameter int unsigned LEN_W  = 5
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [CODE_W-1:0] code_in,
  input  logic [LEN_W-1:0]  code_len,
  input  logic              code_valid,
  input  logic              flush,
  output logic [31:0]       dout,
  output logic              dout_valid,
  output logic              flush_done,
`ifdef JPEG_BIT_PACKER_WCNT_EN
  output logic [31:0]       word_cnt,
`endif
  output logic              err
);

  localparam logic StRun   = 1'b0;
  localparam logic StFlush = 1'b1;

  logic        state_q, state_d;
  logic [63:0] acc_q, acc_d;        // left-aligned pending bits
  logic [4:0]  cnt_q, cnt_d;        // number of pending bits, 0..31
  logic [31:0] dout_q, dout_d;
  logic        dout_valid_q, dout_valid_d;
  logic        flush_done_q, flush_done_d;
  logic        err_q, err_d;

  logic [63:0] code_ext;
  logic [63:0] len_mask;
  logic [63:0] masked;
  logic [63:0] merged;
  logic [6:0]  total;
  logic [6:0]  shamt;
  logic        len_ok;

  // Datapath for absorbing one code into the accumulator.
  always_comb begin
    code_ext = 64'(code_in);
    len_mask = (64'd1 << code_len) - 64'd1;
    masked   = code_ext & len_mask;
    total    = 7'(cnt_q) + 7'(code_len);
    // Place the code just below the pending bits; only used when code_len > 0,
    // so the shift is at most 63.
    shamt    = 7'd64 - total;
    merged   = acc_q | (masked << shamt);
    len_ok   = (32'(code_len) <= CODE_W);
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    flush_done_d = 1'b0;
    err_d        = err_q;

    case (state_q)
      StRun: begin
        // A code arriving with flush is absorbed first; the flush cycle then
        // sees the updated accumulator.
        if (code_valid) begin
          if (!len_ok) begin
            err_d = 1'b1;
          end else if (code_len != '0) begin
            if (total >= 7'd32) begin
              dout_d       = merged[63:32];
              dout_valid_d = 1'b1;
              acc_d        = merged << 32;
              cnt_d        = 5'(total - 7'd32);
            end else begin
              acc_d = merged;
              cnt_d = 5'(total);
            end
          end
        end
        if (flush) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (code_valid) begin
          err_d = 1'b1;
        end
        if (cnt_q != '0) begin
          // Bits below the residual are filled with 1s.
          dout_d       = acc_q[63:32] | (32'hFFFF_FFFF >> cnt_q);
          dout_valid_d = 1'b1;
        end
        acc_d        = '0;
        cnt_d        = '0;
        flush_done_d = 1'b1;
        state_d      = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= StRun;
      acc_q        <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      flush_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      flush_done_q <= flush_done_d;
      err_q        <= err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign flush_done = flush_done_q;
  assign err        = err_q;

`ifdef JPEG_BIT_PACKER_WCNT_EN
  logic [31:0] word_cnt_q, word_cnt_d;

  // The count is visible in full (flush word included) while flush_done is
  // high, then restarts from the next word.
  always_comb begin
    word_cnt_d = flush_done_q ? 32'd0 : word_cnt_q;
    if (dout_valid_d) begin
      word_cnt_d = word_cnt_d + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      word_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
    end
  end

  assign word_cnt = word_cnt_q;
`endif

endmodule
